golomb_job_controller: RTL and testbench

- Host-side driver for the ruler search assembly: accepts search jobs (preset mark prefix plus job id) on a valid/ready stream.
- Loads `firstvalues` and pulses the assembly reset, then waits for `done`.
- Drains the stored results as one record per ruler on an output valid/ready stream.
- Sits between the host link and one assembly instance; it is the initiator for which the assembly is the responder.

---
 rtl/golomb_job_controller_pkg.sv | 24 ++
 rtl/golomb_job_controller_if.sv | 31 +++
 rtl/golomb_ruler_checker.sv | 34 +++
 rtl/golomb_job_controller.sv | 155 +++++++++++++++
 tb/tb_golomb_job_controller.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/golomb_job_controller_pkg.sv
// Shared types and widths for the Golomb ruler job controller.
`ifndef GJC_REC_W
`define GJC_REC_W(np, vb) (((np) + 1) * (vb))
`define GJC_RES_W(nr, np, vb) ((nr) * `GJC_REC_W(np, vb))
`endif

package golomb_job_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        RUN,
        DRAIN,
        EMIT1
    } state_e;

    typedef enum logic [1:0] {
        RES_OK      = 2'd0,
        RES_NONE    = 2'd1,
        RES_TIMEOUT = 2'd2,
        RES_BAD     = 2'd3
    } status_e;

endpackage

// File: rtl/golomb_job_controller_if.sv
// Host link of the job controller: job stream in, result record stream out.
interface golomb_job_controller_if #(
    parameter int RW = 54,
    parameter int VB = 9
);
    logic          job_valid;
    logic          job_ready;
    logic [RW-1:0] job_prefix;
    logic [7:0]    job_id;

    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_id;
    logic [RW-1:0] res_ruler;
    logic [VB-1:0] res_length;
    logic [2:0]    res_index;
    logic          res_last;
    logic [1:0]    res_status;

    modport master (
        output job_valid, job_prefix, job_id, res_ready,
        input  job_ready, res_valid, res_id, res_ruler,
        input  res_length, res_index, res_last, res_status
    );

    modport slave (
        input  job_valid, job_prefix, job_id, res_ready,
        output job_ready, res_valid, res_id, res_ruler,
        output res_length, res_index, res_last, res_status
    );
endinterface

// File: rtl/golomb_ruler_checker.sv
// Combinational Golomb property check: strictly increasing marks, distinct distances.
module golomb_ruler_checker #(
    parameter int NUMPOSITIONS = 5,
    parameter int VALUE_BITS   = 9
) (
    input  logic [(NUMPOSITIONS+1)*VALUE_BITS-1:0] ruler,
    output logic                                   ok
);
    logic [VALUE_BITS-1:0]      m [NUMPOSITIONS+1];
    logic [2**VALUE_BITS-1:0]   seen;
    logic [VALUE_BITS-1:0]      d;
    logic                       inc;
    logic                       dup;

    always_comb begin
        seen = '0;
        d    = '0;
        inc  = 1'b1;
        dup  = 1'b0;
        for (int i = 0; i <= NUMPOSITIONS; i++)
            m[i] = ruler[(NUMPOSITIONS-i)*VALUE_BITS +: VALUE_BITS];
        for (int i = 0; i < NUMPOSITIONS; i++)
            if (m[i+1] <= m[i]) inc = 1'b0;
        // one-hot distance set: a second hit on any bit is a repeat
        for (int i = 0; i < NUMPOSITIONS; i++) begin
            for (int j = i + 1; j <= NUMPOSITIONS; j++) begin
                d = m[j] - m[i];
                if (seen[d]) dup = 1'b1;
                seen[d] = 1'b1;
            end
        end
        ok = inc && !dup;
    end
endmodule

// File: rtl/golomb_job_controller.sv
// Drives one ruler search assembly per job and drains its results as records.
// Optional ruler validation: define GOLOMB_RESULT_CHECK_EN.
module golomb_job_controller
    import golomb_job_controller_pkg::*;
#(
    parameter int NUMPOSITIONS   = 5,
    parameter int VALUE_BITS     = 9,
    parameter int NUM_RESULTS    = 5,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int RW = `GJC_REC_W(NUMPOSITIONS, VALUE_BITS),
    localparam int AW = `GJC_RES_W(NUM_RESULTS, NUMPOSITIONS, VALUE_BITS)
) (
    input  logic                  FXCLK,
    input  logic                  RESET_IN,
    golomb_job_controller_if.slave bus,
    output logic                  asm_reset,
    output logic [RW-1:0]         asm_firstvalues,
    input  logic                  asm_done,
    input  logic [5:0]            asm_numresults,
    input  logic [AW-1:0]         asm_results,
    output logic                  busy
);
    localparam int CMAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
    localparam logic [5:0] NR6 = 6'(NUM_RESULTS);

    state_e          state_q, state_d;
    status_e         status_q, status_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      k_q, k_d;
    logic [RW-1:0]   fv_q;
    logic [7:0]      id_q;
    logic [RW-1:0]   buf_q [NUM_RESULTS];
    logic [RW-1:0]   cur;
    logic            accept, cap, hs, chk_ok;

    assign hs = bus.res_valid && bus.res_ready;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        k_d      = k_q;
        accept   = 1'b0;
        cap      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.job_valid) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = RESET;
                end
            end
            RESET: begin
                if (int'(cnt_q) == RESET_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                // cnt_q==0 is the first cycle after asm_reset fell: done may be stale
                if (asm_done && cnt_q != '0) begin
                    cap = 1'b1;
                    if (asm_numresults == 6'd0) begin
                        status_d = RES_NONE;
                        state_d  = EMIT1;
                    end else begin
                        k_d     = (asm_numresults > NR6) ? NR6[2:0] : asm_numresults[2:0];
                        idx_d   = 3'd1;
                        state_d = DRAIN;
                    end
                end else if (TIMEOUT_CYCLES > 0 && int'(cnt_q) + 1 == TIMEOUT_CYCLES) begin
                    status_d = RES_TIMEOUT;
                    state_d  = EMIT1;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (idx_q == k_q) state_d = IDLE;
                    else idx_d = idx_q + 3'd1;
                end
            end
            EMIT1: begin
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge FXCLK) begin
        if (RESET_IN) begin
            state_q  <= IDLE;
            status_q <= RES_OK;
            cnt_q    <= '0;
            idx_q    <= '0;
            k_q      <= '0;
            fv_q     <= '0;
            id_q     <= '0;
            for (int i = 0; i < NUM_RESULTS; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            k_q      <= k_d;
            if (accept) begin
                fv_q <= bus.job_prefix;
                id_q <= bus.job_id;
            end
            if (cap)
                for (int i = 0; i < NUM_RESULTS; i++)
                    buf_q[i] <= asm_results[(NUM_RESULTS-1-i)*RW +: RW];
        end
    end

    always_comb begin
        cur = '0;
        if (state_q == DRAIN) cur = buf_q[idx_q - 3'd1];
    end

`ifdef GOLOMB_RESULT_CHECK_EN
    golomb_ruler_checker #(
        .NUMPOSITIONS(NUMPOSITIONS),
        .VALUE_BITS  (VALUE_BITS)
    ) u_chk (
        .ruler(cur),
        .ok   (chk_ok)
    );
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        bus.res_status = RES_OK;
        if (state_q == EMIT1) bus.res_status = status_q;
        else if (state_q == DRAIN && !chk_ok) bus.res_status = RES_BAD;
    end

    assign bus.job_ready  = (state_q == IDLE);
    assign asm_reset      = (state_q == IDLE) || (state_q == RESET);
    assign busy           = (state_q != IDLE);
    assign asm_firstvalues = fv_q;
    assign bus.res_valid  = (state_q == DRAIN) || (state_q == EMIT1);
    assign bus.res_id     = id_q;
    assign bus.res_ruler  = cur;
    assign bus.res_length = cur[VALUE_BITS-1:0];
    assign bus.res_index  = (state_q == DRAIN) ? idx_q : 3'd0;
    assign bus.res_last   = (state_q == EMIT1) || ((state_q == DRAIN) && (idx_q == k_q));
endmodule

// File: tb/tb_golomb_job_controller.sv
// Scoreboard bench for golomb_job_controller with a directed assembly model.
module tb_golomb_job_controller;
    localparam int NP = 5;
    localparam int VB = 9;
    localparam int NR = 5;
    localparam int RC = 4;
    localparam int TO = 50;
    localparam int RW = (NP + 1) * VB;
`ifdef GOLOMB_RESULT_CHECK_EN
    localparam logic [1:0] BAD_EXP = 2'd3;
`else
    localparam logic [1:0] BAD_EXP = 2'd0;
`endif

    logic FXCLK = 1'b0;
    logic RESET_IN = 1'b1;
    logic asm_reset;
    logic [RW-1:0] asm_firstvalues;
    logic asm_done = 1'b0;
    logic [5:0] asm_numresults = 6'd0;
    logic [NR*RW-1:0] asm_results = '0;
    logic busy;

    always #5 FXCLK = ~FXCLK;

    golomb_job_controller_if #(.RW(RW), .VB(VB)) bus ();

    golomb_job_controller #(
        .NUMPOSITIONS  (NP),
        .VALUE_BITS    (VB),
        .NUM_RESULTS   (NR),
        .RESET_CYCLES  (RC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .FXCLK          (FXCLK),
        .RESET_IN       (RESET_IN),
        .bus            (bus),
        .asm_reset      (asm_reset),
        .asm_firstvalues(asm_firstvalues),
        .asm_done       (asm_done),
        .asm_numresults (asm_numresults),
        .asm_results    (asm_results),
        .busy           (busy)
    );

    typedef struct {
        logic [7:0]    id;
        logic [RW-1:0] ruler;
        logic [2:0]    index;
        logic          last;
        logic [1:0]    status;
    } rec_t;

    rec_t expq[$];
    rec_t mon_e;
    int checks = 0;
    int passes = 0;
    logic stall_p = 1'b0;
    logic [77:0] snap;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [77:0] outs();
        return {bus.res_valid, bus.res_id, bus.res_ruler, bus.res_length,
                bus.res_index, bus.res_last, bus.res_status};
    endfunction

    function automatic logic [RW-1:0] rul(int a, int b, int c, int d, int e, int f);
        return {9'(a), 9'(b), 9'(c), 9'(d), 9'(e), 9'(f)};
    endfunction

    task automatic push(input logic [7:0] id, input logic [RW-1:0] r,
                        input int idx, input bit last, input logic [1:0] st);
        rec_t x;
        x.id = id;
        x.ruler = r;
        x.index = 3'(idx);
        x.last = last;
        x.status = st;
        expq.push_back(x);
    endtask

    // monitor: compare every completed record, and hold-stability during stalls
    always @(negedge FXCLK) begin
        if (!RESET_IN && bus.res_valid) begin
            if (stall_p) chk("stall_stable", outs(), snap);
            if (bus.res_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_record: got index %0d id %0h expected none",
                             bus.res_index, bus.res_id);
                end else begin
                    mon_e = expq.pop_front();
                    chk("res_id", bus.res_id, mon_e.id);
                    chk("res_ruler", bus.res_ruler, mon_e.ruler);
                    chk("res_length", bus.res_length, mon_e.ruler[VB-1:0]);
                    chk("res_index", bus.res_index, mon_e.index);
                    chk("res_last", bus.res_last, mon_e.last);
                    chk("res_status", bus.res_status, mon_e.status);
                end
                stall_p = 1'b0;
            end else begin
                stall_p = 1'b1;
                snap = outs();
            end
        end else begin
            stall_p = 1'b0;
        end
    end

    task automatic tick();
        @(posedge FXCLK);
        #1;
    endtask

    task automatic start_job(input logic [RW-1:0] pre, input logic [7:0] id);
        int n;
        chk("job_ready_idle", bus.job_ready, 1'b1);
        bus.job_valid = 1'b1;
        bus.job_prefix = pre;
        bus.job_id = id;
        tick();
        bus.job_valid = 1'b0;
        chk("job_ready_drop", bus.job_ready, 1'b0);
        chk("busy_start", busy, 1'b1);
        chk("firstvalues", asm_firstvalues, pre);
        n = 0;
        while (asm_reset && n < 100) begin
            n++;
            tick();
        end
        chk("reset_cycles", n, RC);
    endtask

    task automatic done_pulse(input logic [5:0] num, input logic [NR*RW-1:0] res);
        asm_numresults = num;
        asm_results = res;
        asm_done = 1'b1;
        tick();
        asm_done = 1'b0;
    endtask

    task automatic finish_job();
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("busy_end", busy, 1'b0);
        chk("queue_drained", expq.size(), 0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.res_valid && n < 200) begin
            tick();
            n++;
        end
        chk("res_valid_seen", bus.res_valid, 1'b1);
    endtask

    initial begin
        int n;
        logic [RW-1:0] r1, r2, r3, rb;
        bus.job_valid = 1'b0;
        bus.job_prefix = '0;
        bus.job_id = 8'h00;
        bus.res_ready = 1'b1;
        r1 = rul(0, 1, 4, 10, 12, 17);
        r2 = rul(0, 1, 8, 11, 13, 17);
        r3 = rul(0, 2, 7, 13, 21, 22);
        rb = rul(0, 1, 2, 4, 5, 9);
        repeat (3) tick();
        chk("rst_job_ready", bus.job_ready, 1'b1);
        chk("rst_asm_reset", asm_reset, 1'b1);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_firstvalues", asm_firstvalues, 0);
        RESET_IN = 1'b0;
        tick();

        // two results, preceded by a stale done in the first run cycle
        start_job('0, 8'h11);
        chk("asm_reset_run", asm_reset, 1'b0);
        asm_numresults = 6'd3;
        asm_results = '1;
        asm_done = 1'b1;
        tick();
        asm_done = 1'b0;
        tick();
        push(8'h11, r1, 1, 1'b0, 2'd0);
        push(8'h11, r2, 2, 1'b1, 2'd0);
        done_pulse(6'd2, {r1, r2, rul(0, 0, 0, 0, 0, 0), r3, r3});
        finish_job();

        // no results
        start_job(rul(0, 1, 0, 0, 0, 0), 8'h22);
        tick();
        push(8'h22, '0, 0, 1'b1, 2'd1);
        done_pulse(6'd0, '0);
        finish_job();

        // timeout: done never rises
        start_job('0, 8'h33);
        push(8'h33, '0, 0, 1'b1, 2'd2);
        bus.res_ready = 1'b0;
        n = 1;
        while (!bus.res_valid && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycle", n, 51);
        chk("busy_timeout", busy, 1'b1);
        bus.res_ready = 1'b1;
        tick();
        chk("busy_after_timeout", busy, 1'b0);
        chk("queue_timeout", expq.size(), 0);

        // ten-cycle stall during drain
        start_job('0, 8'h44);
        bus.res_ready = 1'b0;
        tick();
        push(8'h44, r1, 1, 1'b0, 2'd0);
        push(8'h44, r2, 2, 1'b0, 2'd0);
        push(8'h44, r3, 3, 1'b1, 2'd0);
        done_pulse(6'd3, {r1, r2, r3, rb, rb});
        wait_valid();
        repeat (10) tick();
        chk("stall_index", bus.res_index, 3'd1);
        bus.res_ready = 1'b1;
        finish_job();

        // result count saturates at NUM_RESULTS
        start_job('0, 8'h55);
        tick();
        push(8'h55, r3, 1, 1'b0, 2'd0);
        push(8'h55, r2, 2, 1'b0, 2'd0);
        push(8'h55, r1, 3, 1'b0, 2'd0);
        push(8'h55, r2, 4, 1'b0, 2'd0);
        push(8'h55, r3, 5, 1'b1, 2'd0);
        done_pulse(6'd9, {r3, r2, r1, r2, r3});
        finish_job();

        // repeated distance 1
        start_job('0, 8'h66);
        tick();
        push(8'h66, rb, 1, 1'b1, BAD_EXP);
        done_pulse(6'd1, {rb, r1, r1, r1, r1});
        finish_job();

        // reset in the middle of a drain
        start_job('0, 8'h77);
        bus.res_ready = 1'b0;
        tick();
        done_pulse(6'd2, {r1, r2, r3, r3, r3});
        wait_valid();
        tick();
        RESET_IN = 1'b1;
        tick();
        chk("midrst_res_valid", bus.res_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_asm_reset", asm_reset, 1'b1);
        chk("midrst_res_id", bus.res_id, 8'h00);
        RESET_IN = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        chk("midrst_no_partial", bus.res_valid, 1'b0);
        start_job(r1, 8'h88);
        tick();
        push(8'h88, r2, 1, 1'b1, 2'd0);
        done_pulse(6'd1, {r2, r1, r1, r1, r1});
        finish_job();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
